// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: decodes CMD17/CMD24 frames on MOSI and serves
// single 64-bit blocks from an internal array over MISO.
module sd_spi_card_responder #(
  parameter int ADDR_W      = 4,
  parameter int RESP_WAIT   = 2,
  parameter int DATA_WAIT   = 4,
  parameter int BUSY_CYCLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       rd_done,
  output logic       wr_done,
  output logic [7:0] last_r1
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CMD_RX   = 4'd1,
    S_RESP_GAP = 4'd2,
    S_RESP_TX  = 4'd3,
    S_RD_GAP   = 4'd4,
    S_RD_TX    = 4'd5,
    S_WR_TOKEN = 4'd6,
    S_WR_RX    = 4'd7,
    S_WR_DRESP = 4'd8,
    S_WR_BUSY  = 4'd9
  } state_t;

  localparam logic [7:0] RESP_LAST = 8'(RESP_WAIT - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_WAIT - 1);
  localparam logic [7:0] BUSY_LAST = 8'(BUSY_CYCLES - 1);

  function automatic logic [6:0] crc7_f(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_f(input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'd0;
    for (int i = 63; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [7:0]    cnt_r, cnt_nxt_s;
  logic          miso_r, miso_nxt_s;
  logic          rd_done_r, rd_done_nxt_s;
  logic          wr_done_r, wr_done_nxt_s;
  logic [7:0]    last_r1_r, last_r1_nxt_s;
  logic [7:0]    r1_r, r1_nxt_s, r1_calc_s;
  logic [46:0]   cmd_sr_r, cmd_sr_nxt_s;
  logic [87:0]   rd_sr_r, rd_sr_nxt_s;
  logic [79:0]   wr_sr_r, wr_sr_nxt_s;
  logic          wr_ok_r, wr_ok_nxt_s;
  logic          mem_we_s;
  logic [63:0]   mem_r [0:(1<<ADDR_W)-1];

  logic [47:0]       frame_s;
  logic [79:0]       wr_full_s;
  logic [ADDR_W-1:0] blk_addr_s;
  logic [63:0]       rd_blk_s;
  logic              wr_crc_ok_s;
  logic [7:0]        dresp_s;

  // After CMD_RX completes, cmd_sr_r holds frame bits 46..0, so the index and
  // block address stay valid for the whole transaction.
  assign frame_s     = {cmd_sr_r, MOSI};
  assign wr_full_s   = {wr_sr_r[78:0], MOSI};
  assign blk_addr_s  = cmd_sr_r[8 +: ADDR_W];
  assign rd_blk_s    = mem_r[blk_addr_s];
  assign wr_crc_ok_s = (crc16_f(wr_full_s[79:16]) == wr_full_s[15:0]);
  assign dresp_s     = wr_ok_r ? 8'h05 : 8'h0B;

  // R1 classification of a just-completed command frame, in priority order.
  always_comb begin
    r1_calc_s = 8'h00;
    if ((crc7_f(frame_s[47:8]) != frame_s[7:1]) || !frame_s[0]) begin
      r1_calc_s = 8'h08;
    end else if ((frame_s[45:40] != 6'd17) && (frame_s[45:40] != 6'd24)) begin
      r1_calc_s = 8'h04;
    end else if ((frame_s[39:8] >> ADDR_W) != 32'd0) begin
      r1_calc_s = 8'h20;
    end else begin
      r1_calc_s = 8'h00;
    end
  end

  // Next-state and next-output logic of the card FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    miso_nxt_s    = 1'b1;
    rd_done_nxt_s = 1'b0;
    wr_done_nxt_s = 1'b0;
    last_r1_nxt_s = last_r1_r;
    r1_nxt_s      = r1_r;
    cmd_sr_nxt_s  = cmd_sr_r;
    rd_sr_nxt_s   = rd_sr_r;
    wr_sr_nxt_s   = wr_sr_r;
    wr_ok_nxt_s   = wr_ok_r;
    mem_we_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!MOSI) begin
          state_nxt_s  = S_CMD_RX;
          cnt_nxt_s    = 8'd1;
          cmd_sr_nxt_s = 47'd0;
        end else begin
          cnt_nxt_s = 8'd0;
        end
      end
      S_CMD_RX: begin
        cmd_sr_nxt_s = frame_s[46:0];
        cnt_nxt_s    = cnt_r + 8'd1;
        if ((cnt_r == 8'd1) && !MOSI) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r == 8'd47) begin
          r1_nxt_s    = r1_calc_s;
          state_nxt_s = S_RESP_GAP;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = S_CMD_RX;
        end
      end
      S_RESP_GAP: begin
        if (cnt_r == RESP_LAST) begin
          state_nxt_s   = S_RESP_TX;
          cnt_nxt_s     = 8'd0;
          miso_nxt_s    = r1_r[7];
          last_r1_nxt_s = r1_r;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      S_RESP_TX: begin
        if (cnt_r == 8'd7) begin
          cnt_nxt_s = 8'd0;
          if (r1_r != 8'h00) begin
            state_nxt_s = S_IDLE;
          end else if (cmd_sr_r[45:40] == 6'd17) begin
            state_nxt_s = S_RD_GAP;
            rd_sr_nxt_s = {8'hFE, rd_blk_s, crc16_f(rd_blk_s)};
          end else begin
            state_nxt_s = S_WR_TOKEN;
          end
        end else begin
          miso_nxt_s = r1_r[3'd6 - cnt_r[2:0]];
          cnt_nxt_s  = cnt_r + 8'd1;
        end
      end
      S_RD_GAP: begin
        if (cnt_r == DATA_LAST) begin
          state_nxt_s = S_RD_TX;
          cnt_nxt_s   = 8'd0;
          miso_nxt_s  = rd_sr_r[87];
          rd_sr_nxt_s = {rd_sr_r[86:0], 1'b0};
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      S_RD_TX: begin
        if (cnt_r == 8'd87) begin
          state_nxt_s   = S_IDLE;
          cnt_nxt_s     = 8'd0;
          rd_done_nxt_s = 1'b1;
        end else begin
          miso_nxt_s  = rd_sr_r[87];
          rd_sr_nxt_s = {rd_sr_r[86:0], 1'b0};
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      S_WR_TOKEN: begin
        if (!MOSI) begin
          state_nxt_s = S_WR_RX;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = S_WR_TOKEN;
        end
      end
      S_WR_RX: begin
        wr_sr_nxt_s = wr_full_s;
        if (cnt_r == 8'd79) begin
          state_nxt_s = S_WR_DRESP;
          cnt_nxt_s   = 8'd0;
          wr_ok_nxt_s = wr_crc_ok_s;
          miso_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      S_WR_DRESP: begin
        if (cnt_r == 8'd7) begin
          cnt_nxt_s = 8'd0;
          if (wr_ok_r) begin
            state_nxt_s = S_WR_BUSY;
            miso_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          miso_nxt_s = dresp_s[3'd6 - cnt_r[2:0]];
          cnt_nxt_s  = cnt_r + 8'd1;
        end
      end
      S_WR_BUSY: begin
        if (cnt_r == BUSY_LAST) begin
          mem_we_s      = 1'b1;
          wr_done_nxt_s = 1'b1;
          state_nxt_s   = S_IDLE;
          cnt_nxt_s     = 8'd0;
        end else begin
          miso_nxt_s = 1'b0;
          cnt_nxt_s  = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= 8'd0;
      miso_r    <= 1'b1;
      rd_done_r <= 1'b0;
      wr_done_r <= 1'b0;
      last_r1_r <= 8'h00;
      r1_r      <= 8'h00;
      cmd_sr_r  <= 47'd0;
      rd_sr_r   <= 88'd0;
      wr_sr_r   <= 80'd0;
      wr_ok_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      miso_r    <= miso_nxt_s;
      rd_done_r <= rd_done_nxt_s;
      wr_done_r <= wr_done_nxt_s;
      last_r1_r <= last_r1_nxt_s;
      r1_r      <= r1_nxt_s;
      cmd_sr_r  <= cmd_sr_nxt_s;
      rd_sr_r   <= rd_sr_nxt_s;
      wr_sr_r   <= wr_sr_nxt_s;
      wr_ok_r   <= wr_ok_nxt_s;
    end
  end

  // Block array; contents survive reset, write lands on the last busy cycle.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[blk_addr_s] <= wr_sr_r[79:16];
    end
  end

  assign MISO    = miso_r;
  assign rd_done = rd_done_r;
  assign wr_done = wr_done_r;
  assign last_r1 = last_r1_r;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: host-side CMD17/CMD24 traffic
// with hand-derived expected responses and an independent CRC reference.
module tb_sd_spi_card_responder;

  localparam int RESP_WAIT   = 2;
  localparam int DATA_WAIT   = 4;
  localparam int BUSY_CYCLES = 6;

  localparam logic [63:0] D3 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D5 = 64'hFEDCBA9876543210;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       MOSI = 1'b1;
  logic       MISO;
  logic       rd_done;
  logic       wr_done;
  logic [7:0] last_r1;

  int n_checks = 0;
  int n_pass = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  int both_pulses = 0;

  sd_spi_card_responder #(
    .ADDR_W(4), .RESP_WAIT(RESP_WAIT), .DATA_WAIT(DATA_WAIT), .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .MISO(MISO),
    .rd_done(rd_done), .wr_done(wr_done), .last_r1(last_r1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_done) rd_pulses++;
    if (wr_done) wr_pulses++;
    if (rd_done && wr_done) both_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Long-division form of the CRCs, independent of the LFSR form.
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'd0};
    for (int i = 46; i >= 7; i--) if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [15:0] ref_crc16(input logic [63:0] m);
    logic [79:0] v;
    v = {m, 16'd0};
    for (int i = 79; i >= 16; i--) if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
    return v[15:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic bad);
    logic [39:0] body;
    logic [6:0]  crc;
    body = {2'b01, idx, arg};
    crc  = ref_crc7(body) ^ {6'd0, bad};
    return {body, crc, 1'b1};
  endfunction

  // One bit period: sample MISO for this cycle, then present the next MOSI bit.
  task automatic step(input logic m, output logic so);
    @(negedge clk);
    so = MISO;
    MOSI = m;
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic so;
    for (int i = 47; i >= 0; i--) step(f[i], so);
  endtask

  task automatic recv_after_gap(output int gap, output logic [7:0] b);
    logic so;
    gap = 0;
    step(1'b1, so);
    while (so && gap < 300) begin
      gap++;
      step(1'b1, so);
    end
    b[7] = so;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, so);
      b[i] = so;
    end
  endtask

  task automatic recv_bits(input int n, output logic [63:0] v);
    logic so;
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, so);
      v = {v[62:0], so};
    end
  endtask

  task automatic count_idle_zeros(input int n, output int zeros);
    logic so;
    zeros = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, so);
      if (!so) zeros++;
    end
  endtask

  task automatic expect_r1(input string tag, input logic [47:0] f, input logic [7:0] exp);
    int         gap;
    logic [7:0] b;
    send_frame(f);
    recv_after_gap(gap, b);
    check_eq({tag, "_gap"}, 64'(gap), 64'(RESP_WAIT));
    check_eq({tag, "_r1"}, 64'(b), 64'(exp));
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [63:0] data,
                          input logic [15:0] crc, input logic ok);
    logic [87:0] pkt;
    logic [7:0]  b;
    logic        so;
    int          gap, nz, wp;
    expect_r1(tag, mk_cmd(6'd24, addr, 1'b0), 8'h00);
    pkt = {8'hFE, data, crc};
    for (int i = 87; i >= 0; i--) step(pkt[i], so);
    wp = wr_pulses;
    recv_after_gap(gap, b);
    check_eq({tag, "_dresp_gap"}, 64'(gap), 64'd0);
    check_eq({tag, "_dresp"}, 64'(b), ok ? 64'h05 : 64'h0B);
    if (ok) begin
      nz = 0;
      step(1'b1, so);
      while (!so && nz < 300) begin
        nz++;
        step(1'b1, so);
      end
      check_eq({tag, "_busy_len"}, 64'(nz), 64'(BUSY_CYCLES));
      check_eq({tag, "_wr_done"}, 64'(wr_done), 64'd1);
      step(1'b1, so);
      check_eq({tag, "_wr_done_1cyc"}, 64'(wr_done), 64'd0);
    end else begin
      count_idle_zeros(20, nz);
      check_eq({tag, "_no_busy"}, 64'(nz), 64'd0);
      check_eq({tag, "_no_wr_done"}, 64'(wr_pulses - wp), 64'd0);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [63:0] exp);
    logic [63:0] v;
    logic        so;
    int          n1;
    expect_r1(tag, mk_cmd(6'd17, addr, 1'b0), 8'h00);
    n1 = 0;
    step(1'b1, so);
    while (so && n1 < 300) begin
      n1++;
      step(1'b1, so);
    end
    check_eq({tag, "_token_pos"}, 64'(n1), 64'(DATA_WAIT + 7));
    recv_bits(64, v);
    check_eq({tag, "_data"}, v, exp);
    recv_bits(16, v);
    check_eq({tag, "_crc16"}, v, 64'(ref_crc16(exp)));
    step(1'b1, so);
    check_eq({tag, "_idle_after"}, 64'(so), 64'd1);
    check_eq({tag, "_rd_done"}, 64'(rd_done), 64'd1);
    step(1'b1, so);
    check_eq({tag, "_rd_done_1cyc"}, 64'(rd_done), 64'd0);
  endtask

  initial begin
    int          z, rp, wp;
    logic [63:0] v;
    logic        so;

    repeat (3) @(negedge clk);
    check_eq("rst_miso", 64'(MISO), 64'd1);
    check_eq("rst_pulses", 64'({rd_done, wr_done}), 64'd0);
    check_eq("rst_last_r1", 64'(last_r1), 64'h00);
    rst_n = 1'b1;

    count_idle_zeros(100, z);
    check_eq("idle_miso", 64'(z), 64'd0);
    check_eq("idle_pulses", 64'(rd_pulses + wr_pulses), 64'd0);
    check_eq("idle_last_r1", 64'(last_r1), 64'h00);

    do_write("wr3", 32'd3, D3, ref_crc16(D3), 1'b1);
    do_read("rd3", 32'd3, D3);

    do_write("wr5", 32'd5, D5, ref_crc16(D5), 1'b1);
    do_write("wr5_bad", 32'd5, 64'd0, 16'h0001, 1'b0);
    do_read("rd5", 32'd5, D5);

    rp = rd_pulses;
    expect_r1("bad_crc", mk_cmd(6'd17, 32'd3, 1'b1), 8'h08);
    check_eq("bad_crc_last_r1", 64'(last_r1), 64'h08);
    count_idle_zeros(40, z);
    check_eq("bad_crc_no_data", 64'(z), 64'd0);
    expect_r1("idx12", mk_cmd(6'd12, 32'd0, 1'b0), 8'h04);
    check_eq("idx12_last_r1", 64'(last_r1), 64'h04);
    count_idle_zeros(40, z);
    check_eq("idx12_no_data", 64'(z), 64'd0);
    expect_r1("arg_range", mk_cmd(6'd17, 32'h0000_0100, 1'b0), 8'h20);
    count_idle_zeros(40, z);
    check_eq("arg_range_no_data", 64'(z), 64'd0);
    check_eq("err_no_rd_done", 64'(rd_pulses - rp), 64'd0);

    // Read block 5, then pull reset while frame bit 40 (data bit 31 = 0) is on MISO.
    expect_r1("rd5_rst", mk_cmd(6'd17, 32'd5, 1'b0), 8'h00);
    recv_bits(DATA_WAIT + 8, v);
    check_eq("rd5_rst_token", v, 64'h0000_0000_0000_0FFE);
    recv_bits(32, v);
    check_eq("rd5_rst_hi", v, 64'h0000_0000_FEDC_BA98);
    step(1'b1, so);
    check_eq("rd5_rst_bit40", 64'(so), 64'd0);
    rp = rd_pulses;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_miso", 64'(MISO), 64'd1);
    check_eq("rst_async_last_r1", 64'(last_r1), 64'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    count_idle_zeros(10, z);
    check_eq("rst_idle_miso", 64'(z), 64'd0);
    check_eq("rst_no_rd_done", 64'(rd_pulses - rp), 64'd0);
    do_read("rd5_again", 32'd5, D5);

    step(1'b0, so);
    step(1'b0, so);
    count_idle_zeros(60, z);
    check_eq("bit46_discard", 64'(z), 64'd0);
    do_read("rd3_after_discard", 32'd3, D3);

    wp = wr_pulses;
    check_eq("wr_done_total", 64'(wp), 64'd2);
    check_eq("pulses_exclusive", 64'(both_pulses), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
